// File: rtl/i2c_target_regif_if.sv
// Register-port bundle between the I2C target and the register file behind it.
//   master : the I2C target. It drives the pointer, the write strobe and data,
//            and the read strobe, and it takes the read data back.
//   slave  : the register file. It returns REG_RDATA one CLK after REG_RDEN.
interface i2c_target_regif_if;
  logic [7:0] REG_ADDR;
  logic       REG_WREN;
  logic [7:0] REG_WDATA;
  logic       REG_RDEN;
  logic [7:0] REG_RDATA;

  modport master (
    output REG_ADDR,
    output REG_WREN,
    output REG_WDATA,
    output REG_RDEN,
    input  REG_RDATA
  );

  modport slave (
    input  REG_ADDR,
    input  REG_WREN,
    input  REG_WDATA,
    input  REG_RDEN,
    output REG_RDATA
  );
endinterface

// File: rtl/i2c_target_regif.sv
// I2C target responder with a byte-addressed register-port back end.
// It decodes START and STOP, matches a 7-bit address, and ACKs every byte.
// The first write byte after the address loads the register pointer.
// Each later write byte produces a write strobe. Read bytes are fetched
// through read strobes.
//
// Ports
//   CLK, RESET_N  system clock, asynchronous active-low reset
//   EN            target enable; 0 forces IDLE and releases SDA
//   SLAVE_ADDR    own 7-bit address
//   SCL_I, SDA_I  asynchronous bus levels
//   SDA_OE        1 pulls SDA low (open drain)
//   BUSY          FSM not in IDLE
//   reg_port      register port (REG_ADDR/WREN/WDATA/RDEN/RDATA)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | not addressed; waits for START
// ADDR     | shifting in the address byte and the R/W bit
// ADDR_ACK | driving the ACK for our address
// WR_BYTE  | shifting in a write byte (pointer or data)
// WR_ACK   | driving the ACK for a write byte
// RD_BYTE  | shifting out a read byte
// RD_ACK   | sampling the master ACK/NACK after a read byte
module i2c_target_regif #(
  parameter int P_SYNC = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       EN,
  input  logic [6:0] SLAVE_ADDR,
  input  logic       SCL_I,
  input  logic       SDA_I,
  output logic       SDA_OE,
  output logic       BUSY,
  i2c_target_regif_if.master reg_port
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
  } state_t;

  // Input conditioning: synchronizer chain, then one delay flop for edges.
  logic [P_SYNC-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[P_SYNC-2:0], SCL_I};
      sda_sync <= {sda_sync[P_SYNC-2:0], SDA_I};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[P_SYNC-1];
  assign sda_s     = sda_sync[P_SYNC-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SCL must be high both before and after the SDA edge to qualify.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  state_t     state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  // Holds the first seven bits. The eighth bit is taken straight from the
  // line on the final rise.
  logic [6:0] rx_sr, rx_sr_nx;
  logic [7:0] tx_sr, tx_sr_nx;
  logic [7:0] ptr, ptr_nx;
  logic       ptr_loaded, ptr_loaded_nx;
  logic       rw, rw_nx;
  // Set on the rising edge inside an ACK bit. The next fall ends that ACK bit.
  logic       ack_seen, ack_seen_nx;
  logic       sda_oe_q, sda_oe_nx;
  logic       rd_load, rd_load_nx;
  logic [7:0] reg_addr_q, reg_addr_nx;
  logic       wren_q, wren_nx;
  logic [7:0] wdata_q, wdata_nx;
  logic       rden_q, rden_nx;
  logic [7:0] rx_byte;

  assign rx_byte = {rx_sr, sda_s};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      rx_sr      <= 7'd0;
      tx_sr      <= 8'd0;
      ptr        <= 8'd0;
      ptr_loaded <= 1'b0;
      rw         <= 1'b0;
      ack_seen   <= 1'b0;
      sda_oe_q   <= 1'b0;
      rd_load    <= 1'b0;
      reg_addr_q <= 8'd0;
      wren_q     <= 1'b0;
      wdata_q    <= 8'd0;
      rden_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      rx_sr      <= rx_sr_nx;
      tx_sr      <= tx_sr_nx;
      ptr        <= ptr_nx;
      ptr_loaded <= ptr_loaded_nx;
      rw         <= rw_nx;
      ack_seen   <= ack_seen_nx;
      sda_oe_q   <= sda_oe_nx;
      rd_load    <= rd_load_nx;
      reg_addr_q <= reg_addr_nx;
      wren_q     <= wren_nx;
      wdata_q    <= wdata_nx;
      rden_q     <= rden_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    rx_sr_nx      = rx_sr;
    tx_sr_nx      = tx_sr;
    ptr_nx        = ptr;
    ptr_loaded_nx = ptr_loaded;
    rw_nx         = rw;
    ack_seen_nx   = ack_seen;
    sda_oe_nx     = sda_oe_q;
    reg_addr_nx   = reg_addr_q;
    wdata_nx      = wdata_q;
    wren_nx       = 1'b0;
    rden_nx       = 1'b0;
    rd_load_nx    = rden_q;

    // Read data is taken the cycle after the strobe. The pointer then advances.
    if (rd_load) begin
      tx_sr_nx = reg_port.REG_RDATA;
      ptr_nx   = ptr + 8'd1;
    end

    if (!EN) begin
      state_nx  = IDLE;
      sda_oe_nx = 1'b0;
    end else if (start_det) begin
      state_nx      = ADDR;
      bit_cnt_nx    = 3'd0;
      sda_oe_nx     = 1'b0;
      ack_seen_nx   = 1'b0;
      ptr_loaded_nx = 1'b0;
    end else if (stop_det) begin
      state_nx  = IDLE;
      sda_oe_nx = 1'b0;
    end else begin
      case (state)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            rx_sr_nx   = rx_byte[6:0];
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_nx    = ADDR_ACK;
                rw_nx       = rx_byte[0];
                ack_seen_nx = 1'b0;
              end else begin
                state_nx = IDLE;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_seen) begin
              sda_oe_nx = 1'b1;
            end else begin
              bit_cnt_nx = 3'd0;
              if (rw) begin
                state_nx  = RD_BYTE;
                sda_oe_nx = ~tx_sr[7];
                tx_sr_nx  = {tx_sr[6:0], 1'b0};
              end else begin
                state_nx  = WR_BYTE;
                sda_oe_nx = 1'b0;
              end
            end
          end else if (scl_rise) begin
            ack_seen_nx = 1'b1;
            if (rw) begin
              rden_nx     = 1'b1;
              reg_addr_nx = ptr;
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise) begin
            rx_sr_nx   = rx_byte[6:0];
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nx    = WR_ACK;
              ack_seen_nx = 1'b0;
              if (ptr_loaded) begin
                wren_nx     = 1'b1;
                reg_addr_nx = ptr;
                wdata_nx    = rx_byte;
                ptr_nx      = ptr + 8'd1;
              end else begin
                ptr_nx        = rx_byte;
                ptr_loaded_nx = 1'b1;
              end
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_seen) begin
              sda_oe_nx = 1'b1;
            end else begin
              state_nx   = WR_BYTE;
              sda_oe_nx  = 1'b0;
              bit_cnt_nx = 3'd0;
            end
          end else if (scl_rise) begin
            ack_seen_nx = 1'b1;
          end
        end

        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              state_nx    = RD_ACK;
              sda_oe_nx   = 1'b0;
              ack_seen_nx = 1'b0;
            end else begin
              sda_oe_nx  = ~tx_sr[7];
              tx_sr_nx   = {tx_sr[6:0], 1'b0};
              bit_cnt_nx = bit_cnt + 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ack_seen_nx = 1'b1;
              rden_nx     = 1'b1;
              reg_addr_nx = ptr;
            end else begin
              state_nx = IDLE;
            end
          end else if (scl_fall && ack_seen) begin
            // The fall that ends the master ACK puts out the next MSB.
            state_nx   = RD_BYTE;
            sda_oe_nx  = ~tx_sr[7];
            tx_sr_nx   = {tx_sr[6:0], 1'b0};
            bit_cnt_nx = 3'd0;
          end
        end

        default: state_nx = IDLE;
      endcase
    end
  end

  assign SDA_OE             = sda_oe_q;
  assign BUSY               = (state != IDLE);
  assign reg_port.REG_ADDR  = reg_addr_q;
  assign reg_port.REG_WREN  = wren_q;
  assign reg_port.REG_WDATA = wdata_q;
  assign reg_port.REG_RDEN  = rden_q;

endmodule
